// File: rtl/axi4_mem_responder.sv
// AXI4 INCR-only responder backed by a byte-enabled RAM.
// Independent read and write FSMs share one memory array.
module axi4_mem_responder #(
   parameter int C_ADDR_WIDTH     = 64,
   parameter int C_DATA_WIDTH     = 512,
   parameter int C_MEM_DEPTH_LOG2 = 10
) (
   input  logic                      ap_clk,
   input  logic                      areset,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                      s_axi_wlast,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic                      s_axi_rlast,
   output logic                      protocol_error
);

   localparam int unsigned STRB_W = C_DATA_WIDTH / 8;
   localparam int unsigned OFF    = $clog2(STRB_W);
   localparam int unsigned DEPTH  = 1 << C_MEM_DEPTH_LOG2;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

   logic [C_DATA_WIDTH-1:0] mem [DEPTH];

   wstate_t                     wst_q, wst_d;
   logic [C_MEM_DEPTH_LOG2-1:0] widx_q, widx_d;
   logic [7:0]                  wlen_q, wlen_d;
   logic [7:0]                  wcnt_q, wcnt_d;
   logic                        awready_q, awready_d;
   logic                        wready_q, wready_d;
   logic                        bvalid_q, bvalid_d;
   logic                        perr_q, perr_d;
   logic                        mem_we;
   logic                        w_last_beat;

   rstate_t                     rst_q, rst_d;
   logic [C_MEM_DEPTH_LOG2-1:0] ridx_q, ridx_d;
   logic [7:0]                  rlen_q, rlen_d;
   logic [7:0]                  rcnt_q, rcnt_d;
   logic                        arready_q, arready_d;
   logic                        rvalid_q, rvalid_d;
   logic                        rlast_q, rlast_d;
   logic [C_DATA_WIDTH-1:0]     rdata_q;
   logic                        rd_en;
   logic [C_MEM_DEPTH_LOG2-1:0] rd_idx;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

   assign w_last_beat = (wcnt_q == wlen_q);

   always_comb begin
      wst_d  = wst_q;
      widx_d = widx_q;
      wlen_d = wlen_q;
      wcnt_d = wcnt_q;
      perr_d = perr_q;
      mem_we = 1'b0;
      case (wst_q)
         W_IDLE: if (s_axi_awvalid && awready_q) begin
            widx_d = s_axi_awaddr[OFF +: C_MEM_DEPTH_LOG2];
            wlen_d = s_axi_awlen;
            wcnt_d = '0;
            wst_d  = W_DATA;
         end
         W_DATA: if (s_axi_wvalid && wready_q) begin
            mem_we = 1'b1;
            widx_d = widx_q + 1'b1;
            wcnt_d = wcnt_q + 8'd1;
            // Burst length is governed by awlen; wlast is only audited.
            if (s_axi_wlast != w_last_beat) perr_d = 1'b1;
            if (w_last_beat) wst_d = W_RESP;
         end
         W_RESP: if (s_axi_bready && bvalid_q) wst_d = W_IDLE;
         default: wst_d = W_IDLE;
      endcase
      awready_d = (wst_d == W_IDLE);
      wready_d  = (wst_d == W_DATA);
      bvalid_d  = (wst_d == W_RESP);
   end

   always_comb begin
      rst_d  = rst_q;
      ridx_d = ridx_q;
      rlen_d = rlen_q;
      rcnt_d = rcnt_q;
      rd_en  = 1'b0;
      rd_idx = ridx_q;
      case (rst_q)
         R_IDLE: if (s_axi_arvalid && arready_q) begin
            ridx_d = s_axi_araddr[OFF +: C_MEM_DEPTH_LOG2];
            rlen_d = s_axi_arlen;
            rcnt_d = '0;
            rst_d  = R_FETCH;
         end
         R_FETCH: begin
            rd_en = 1'b1;
            rst_d = R_DATA;
         end
         R_DATA: if (s_axi_rready && rvalid_q) begin
            if (rcnt_q == rlen_q) begin
               rst_d = R_IDLE;
            end else begin
               // Prefetch the next word on the same edge to sustain 1 beat/cycle.
               ridx_d = ridx_q + 1'b1;
               rcnt_d = rcnt_q + 8'd1;
               rd_en  = 1'b1;
               rd_idx = ridx_q + 1'b1;
            end
         end
         default: rst_d = R_IDLE;
      endcase
      arready_d = (rst_d == R_IDLE);
      rvalid_d  = (rst_d == R_DATA);
      rlast_d   = (rst_d == R_DATA) && (rcnt_d == rlen_d);
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         wst_q     <= W_IDLE;
         widx_q    <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         perr_q    <= 1'b0;
         rst_q     <= R_IDLE;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         wst_q     <= wst_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         perr_q    <= perr_d;
         rst_q     <= rst_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         if (rd_en) rdata_q <= mem[rd_idx];
      end
   end

   // Separate process without reset so the array maps onto block RAM.
   always_ff @(posedge ap_clk) begin
      if (mem_we && !areset) begin
         for (int unsigned i = 0; i < STRB_W; i++) begin
            if (s_axi_wstrb[i]) mem[widx_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
         end
      end
   end

   assign s_axi_awready  = awready_q;
   assign s_axi_wready   = wready_q;
   assign s_axi_bvalid   = bvalid_q;
   assign s_axi_arready  = arready_q;
   assign s_axi_rvalid   = rvalid_q;
   assign s_axi_rlast    = rlast_q;
   assign s_axi_rdata    = rdata_q;
   assign protocol_error = perr_q;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: a word-level memory model feeds a
// queue of expected read beats that is drained as the responder returns data.
module tb_axi4_mem_responder;

   localparam int AW    = 64;
   localparam int DW    = 512;
   localparam int SW    = DW / 8;
   localparam int DEPTH = 1024;

   logic          ap_clk = 1'b0;
   logic          areset = 1'b1;
   logic          awvalid = 1'b0, awready;
   logic [AW-1:0] awaddr = '0;
   logic [7:0]    awlen = '0;
   logic          wvalid = 1'b0, wready;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wstrb = '0;
   logic          wlast = 1'b0;
   logic          bvalid, bready = 1'b0;
   logic          arvalid = 1'b0, arready;
   logic [AW-1:0] araddr = '0;
   logic [7:0]    arlen = '0;
   logic          rvalid, rready = 1'b0;
   logic [DW-1:0] rdata;
   logic          rlast;
   logic          protocol_error;

   always #5 ap_clk = ~ap_clk;

   axi4_mem_responder #(
      .C_ADDR_WIDTH     (AW),
      .C_DATA_WIDTH     (DW),
      .C_MEM_DEPTH_LOG2 (10)
   ) dut (
      .ap_clk         (ap_clk),
      .areset         (areset),
      .s_axi_awvalid  (awvalid),
      .s_axi_awready  (awready),
      .s_axi_awaddr   (awaddr),
      .s_axi_awlen    (awlen),
      .s_axi_wvalid   (wvalid),
      .s_axi_wready   (wready),
      .s_axi_wdata    (wdata),
      .s_axi_wstrb    (wstrb),
      .s_axi_wlast    (wlast),
      .s_axi_bvalid   (bvalid),
      .s_axi_bready   (bready),
      .s_axi_arvalid  (arvalid),
      .s_axi_arready  (arready),
      .s_axi_araddr   (araddr),
      .s_axi_arlen    (arlen),
      .s_axi_rvalid   (rvalid),
      .s_axi_rready   (rready),
      .s_axi_rdata    (rdata),
      .s_axi_rlast    (rlast),
      .protocol_error (protocol_error)
   );

   logic [DW-1:0] mdl [DEPTH];
   logic [DW:0]   exp_q [$];
   logic [DW-1:0] wd [16];
   logic [SW-1:0] ws [16];
   int            n_assert = 0;
   int            n_fail   = 0;

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkw(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   task automatic mdl_write(input int unsigned idx, input logic [DW-1:0] d, input logic [SW-1:0] s);
      for (int b = 0; b < SW; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
   endtask

   // bad >= 0 marks a beat whose wlast is inverted relative to the legal value.
   task automatic do_write(input logic [AW-1:0] addr, input int len, input int bad);
      int unsigned idx;
      idx = 32'(addr[15:6]);
      awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
      for (int t = 0; t < 50 && awready !== 1'b1; t++) @(negedge ap_clk);
      check1("aw_ready", awready, 1'b1);
      @(negedge ap_clk);
      awvalid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k];
         wlast = (k == len) ^ (k == bad);
         check1("b_early", bvalid, 1'b0);
         for (int t = 0; t < 50 && wready !== 1'b1; t++) @(negedge ap_clk);
         check1("w_ready", wready, 1'b1);
         mdl_write((idx + k) % DEPTH, wd[k], ws[k]);
         @(negedge ap_clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      check1("b_valid", bvalid, 1'b1);
   endtask

   task automatic b_accept(input int stall);
      for (int i = 0; i < stall; i++) begin
         check1("b_hold", bvalid, 1'b1);
         check1("aw_blocked", awready, 1'b0);
         @(negedge ap_clk);
      end
      bready = 1'b1;
      @(negedge ap_clk);
      bready = 1'b0;
      check1("b_done", bvalid, 1'b0);
      check1("aw_reopen", awready, 1'b1);
   endtask

   task automatic read_burst(input logic [AW-1:0] addr, input int len, input bit toggle);
      int unsigned   idx;
      logic [DW:0]   e;
      logic [DW-1:0] hold;
      bit            stalled;
      idx = 32'(addr[15:6]);
      for (int k = 0; k <= len; k++) exp_q.push_back({k == len, mdl[(idx + k) % DEPTH]});
      arvalid = 1'b1; araddr = addr; arlen = 8'(len);
      for (int t = 0; t < 50 && arready !== 1'b1; t++) @(negedge ap_clk);
      check1("ar_ready", arready, 1'b1);
      @(negedge ap_clk);
      arvalid = 1'b0;
      check1("r_lat1", rvalid, 1'b0);
      @(negedge ap_clk);
      check1("r_lat2", rvalid, 1'b1);
      stalled = 1'b0;
      hold = '0;
      for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
         if (stalled) checkw("r_stable", {1'b0, rdata}, {1'b0, hold});
         rready  = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
         stalled = rvalid && !rready;
         hold    = rdata;
         if (rvalid && rready) begin
            e = exp_q.pop_front();
            checkw("r_beat", {rlast, rdata}, e);
         end
         @(negedge ap_clk);
      end
      check1("r_complete", exp_q.size() == 0, 1'b1);
      exp_q.delete();
      rready = 1'b0;
      check1("r_end", rvalid, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW:0] e;
      repeat (3) @(negedge ap_clk);
      check1("rst_awready", awready, 1'b0);
      check1("rst_wready", wready, 1'b0);
      check1("rst_bvalid", bvalid, 1'b0);
      check1("rst_arready", arready, 1'b0);
      check1("rst_rvalid", rvalid, 1'b0);
      check1("rst_rlast", rlast, 1'b0);
      check1("rst_perr", protocol_error, 1'b0);
      checkw("rst_rdata", {1'b0, rdata}, '0);
      areset = 1'b0;
      @(negedge ap_clk);
      check1("post_rst_awready", awready, 1'b1);
      check1("post_rst_arready", arready, 1'b1);

      // Single beat write then read back
      wd[0] = {SW{8'hA5}}; ws[0] = '1;
      do_write(64'h40, 0, -1);
      b_accept(0);
      read_burst(64'h40, 0, 1'b0);

      // 4-beat write over an all-ones fill, partial strobe on beat 2
      for (int k = 0; k < 4; k++) begin wd[k] = '1; ws[k] = '1; end
      do_write(64'h0, 3, -1);
      b_accept(0);
      for (int k = 0; k < 4; k++) begin wd[k] = DW'(k); ws[k] = '1; end
      ws[2] = SW'(1);
      do_write(64'h0, 3, -1);
      b_accept(0);
      read_burst(64'h0, 3, 1'b0);

      // 16-beat read under rready backpressure
      for (int k = 0; k < 16; k++) begin wd[k] = rand_word(); ws[k] = '1; end
      do_write(64'h1000, 15, -1);
      b_accept(0);
      read_burst(64'h1000, 15, 1'b1);

      // B held off 5 cycles, next AW right after the B handshake
      wd[0] = rand_word(); ws[0] = '1;
      do_write(64'h200, 0, -1);
      b_accept(5);
      wd[0] = rand_word();
      do_write(64'h240, 0, -1);
      b_accept(0);
      read_burst(64'h200, 1, 1'b0);

      // Early wlast sets the sticky error; length still follows awlen
      check1("perr_clean", protocol_error, 1'b0);
      for (int k = 0; k < 4; k++) begin wd[k] = rand_word(); ws[k] = '1; end
      do_write(64'h800, 3, 1);
      check1("perr_set", protocol_error, 1'b1);
      b_accept(0);
      check1("perr_sticky", protocol_error, 1'b1);
      read_burst(64'h800, 3, 1'b0);

      // Wrap at the top of RAM with a concurrent read of the same words
      wd[0] = rand_word(); ws[0] = '1;
      do_write(64'hFFC0, 0, -1);
      b_accept(0);
      wd[0] = rand_word(); wd[1] = rand_word();
      exp_q.push_back({1'b0, mdl[DEPTH-1]});
      exp_q.push_back({1'b1, mdl[0]});
      check1("dual_awready", awready, 1'b1);
      check1("dual_arready", arready, 1'b1);
      awvalid = 1'b1; awaddr = 64'hFFC0; awlen = 8'd1;
      arvalid = 1'b1; araddr = 64'hFFC0; arlen = 8'd1;
      @(negedge ap_clk);
      awvalid = 1'b0; arvalid = 1'b0;
      wvalid = 1'b1; wdata = wd[0]; wstrb = '1; wlast = 1'b0;
      check1("wrap_wready0", wready, 1'b1);
      check1("wrap_fetch", rvalid, 1'b0);
      @(negedge ap_clk);
      mdl_write(DEPTH - 1, wd[0], '1);
      wdata = wd[1]; wlast = 1'b1;
      check1("wrap_wready1", wready, 1'b1);
      rready = 1'b1;
      check1("wrap_rvalid0", rvalid, 1'b1);
      e = exp_q.pop_front();
      checkw("wrap_old0", {rlast, rdata}, e);
      @(negedge ap_clk);
      mdl_write(0, wd[1], '1);
      wvalid = 1'b0; wlast = 1'b0;
      check1("wrap_rvalid1", rvalid, 1'b1);
      e = exp_q.pop_front();
      checkw("wrap_old1", {rlast, rdata}, e);
      check1("wrap_bvalid", bvalid, 1'b1);
      bready = 1'b1;
      @(negedge ap_clk);
      rready = 1'b0; bready = 1'b0;
      check1("wrap_r_end", rvalid, 1'b0);
      check1("wrap_b_end", bvalid, 1'b0);
      read_burst(64'hFFC0, 1, 1'b0);

      // Reset in the middle of a stalled read burst
      check1("perr_before_reset", protocol_error, 1'b1);
      arvalid = 1'b1; araddr = 64'h1000; arlen = 8'd15; rready = 1'b0;
      for (int t = 0; t < 50 && arready !== 1'b1; t++) @(negedge ap_clk);
      check1("mid_ar_ready", arready, 1'b1);
      @(negedge ap_clk);
      arvalid = 1'b0;
      @(negedge ap_clk);
      check1("mid_rvalid", rvalid, 1'b1);
      areset = 1'b1;
      @(negedge ap_clk);
      check1("mid_rst_rvalid", rvalid, 1'b0);
      check1("mid_rst_arready", arready, 1'b0);
      check1("mid_rst_perr", protocol_error, 1'b0);
      areset = 1'b0;
      @(negedge ap_clk);
      check1("mid_post_arready", arready, 1'b1);
      check1("mid_post_awready", awready, 1'b1);
      check1("mid_post_rvalid", rvalid, 1'b0);
      read_burst(64'h0, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
